// File: rtl/spi_sclk_generator_if.sv
// Frame request, runtime configuration and SCLK/strobe outputs of the SPI clock generator.
// The master drives the frame request; the slave is the generator itself.
interface spi_sclk_generator_if #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 6
);
    logic                 start;
    logic                 abort;
    logic [DIV_WIDTH-1:0] half_div;
    logic [CNT_WIDTH-1:0] bit_count;
    logic                 sclk;
    logic                 launch_strobe;
    logic                 sample_strobe;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output abort,
        output half_div,
        output bit_count,
        input  sclk,
        input  launch_strobe,
        input  sample_strobe,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  half_div,
        input  bit_count,
        output sclk,
        output launch_strobe,
        output sample_strobe,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_sclk_generator.sv
// Framed SPI SCLK generator: divides system_clock by a runtime half-period and emits N-bit bursts.
// Latency: busy from the start edge, edge i at start+i*H, done at start+(2N+1)*H; no backpressure, start ignored while busy.
module spi_sclk_generator #(
    parameter int DIV_WIDTH    = 8,
    parameter int CNT_WIDTH    = 6,
    parameter bit CPOL         = 1'b0,
    parameter bit CPHA         = 1'b1,
    parameter int DEF_HALF_DIV = 6
) (
    input  logic                  system_clock,
    input  logic                  reset,
    spi_sclk_generator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TRAIL  = 2'd2
    } state_t;

    localparam int                   DEF_H    = (DEF_HALF_DIV == 0) ? 1 : DEF_HALF_DIV;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_DEF  = DIV_WIDTH'(DEF_H);
    localparam logic [CNT_WIDTH:0]   EDGE_ONE = (CNT_WIDTH + 1)'(1);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] h_q, h_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [DIV_WIDTH-1:0] half_cnt_q, half_cnt_d;
    logic [CNT_WIDTH:0]   edge_cnt_q, edge_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 launch_q, launch_d;
    logic                 sample_q, sample_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 half_tc;
    logic                 last_edge;
    logic                 leading;

    assign half_tc   = (half_cnt_q == (h_q - DIV_ONE));
    assign last_edge = ((edge_cnt_q + EDGE_ONE) == {n_q, 1'b0});
    // edge_cnt counts completed edges, so the upcoming edge is odd (leading) when it is even
    assign leading   = ~edge_cnt_q[0];

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            h_q        <= DIV_DEF;
            n_q        <= '0;
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= CPOL;
            launch_q   <= 1'b0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            n_q        <= n_d;
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            launch_q   <= launch_d;
            sample_q   <= sample_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        n_d        = n_q;
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        launch_d   = 1'b0;
        sample_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (bus.abort) begin
            state_d    = IDLE;
            sclk_d     = CPOL;
            busy_d     = 1'b0;
            half_cnt_d = '0;
            edge_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        h_d        = (bus.half_div == '0) ? DIV_ONE : bus.half_div;
                        n_d        = bus.bit_count;
                        busy_d     = 1'b1;
                        half_cnt_d = '0;
                        edge_cnt_d = '0;
                        sclk_d     = CPOL;
                        // an empty frame has no bit to present, so no early launch either
                        launch_d   = !CPHA && (bus.bit_count != '0);
                        state_d    = (bus.bit_count == '0) ? TRAIL : ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (half_tc) begin
                        half_cnt_d = '0;
                        sclk_d     = ~sclk_q;
                        edge_cnt_d = edge_cnt_q + EDGE_ONE;
                        if (CPHA) begin
                            launch_d = leading;
                            sample_d = ~leading;
                        end else begin
                            sample_d = leading;
                            launch_d = ~leading && !last_edge;
                        end
                        if (last_edge) begin
                            edge_cnt_d = '0;
                            state_d    = TRAIL;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + DIV_ONE;
                    end
                end

                TRAIL: begin
                    if (half_tc) begin
                        half_cnt_d = '0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        half_cnt_d = half_cnt_q + DIV_ONE;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    sclk_d     = CPOL;
                    busy_d     = 1'b0;
                    half_cnt_d = '0;
                    edge_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.sclk          = sclk_q;
    assign bus.launch_strobe = launch_q;
    assign bus.sample_strobe = sample_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_spi_sclk_generator.sv
// Bench for spi_sclk_generator: two instances (mode 1 CPOL=0/CPHA=1 and CPOL=1/CPHA=0) share stimulus
// and are compared every cycle against a timing-formula reference model.
module tb_spi_sclk_generator;

    logic system_clock = 1'b0;
    logic reset        = 1'b1;

    always #5 system_clock = ~system_clock;

    spi_sclk_generator_if #(.DIV_WIDTH(8), .CNT_WIDTH(6)) bus0 ();
    spi_sclk_generator_if #(.DIV_WIDTH(8), .CNT_WIDTH(6)) bus1 ();

    spi_sclk_generator #(
        .DIV_WIDTH(8), .CNT_WIDTH(6), .CPOL(1'b0), .CPHA(1'b1), .DEF_HALF_DIV(6)
    ) u_dut0 (
        .system_clock (system_clock),
        .reset        (reset),
        .bus          (bus0)
    );

    spi_sclk_generator #(
        .DIV_WIDTH(8), .CNT_WIDTH(6), .CPOL(1'b1), .CPHA(1'b0), .DEF_HALF_DIV(6)
    ) u_dut1 (
        .system_clock (system_clock),
        .reset        (reset),
        .bus          (bus1)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model state per instance: frame active, cycles since start edge, H, N
    int m_act [2];
    int m_t   [2];
    int m_h   [2];
    int m_n   [2];
    int e_sclk[2], e_launch[2], e_sample[2], e_busy[2], e_done[2];

    int cnt_busy[2], cnt_edges[2], cnt_launch[2], cnt_sample[2], cnt_done[2];
    int prev_sclk[2];

    function automatic int cpol_of(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int cpha_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit a, input int hd, input int bc);
        bus0.start     = s;
        bus0.abort     = a;
        bus0.half_div  = 8'(hd);
        bus0.bit_count = 6'(bc);
        bus1.start     = s;
        bus1.abort     = a;
        bus1.half_div  = 8'(hd);
        bus1.bit_count = 6'(bc);
    endtask

    task automatic set_idle(input int d);
        e_sclk[d]   = cpol_of(d);
        e_launch[d] = 0;
        e_sample[d] = 0;
        e_busy[d]   = 0;
        e_done[d]   = 0;
    endtask

    // Outputs as a function of time since the start edge: edge i lands at i*H, done at (2N+1)*H
    task automatic model_step(input bit s, input bit a, input int hd, input int bc);
        for (int d = 0; d < 2; d++) begin
            if (a) begin
                m_act[d] = 0;
            end else if (m_act[d] != 0) begin
                m_t[d]++;
            end else if (s) begin
                m_act[d] = 1;
                m_t[d]   = 0;
                m_h[d]   = (hd == 0) ? 1 : hd;
                m_n[d]   = bc;
            end
            set_idle(d);
            if (m_act[d] != 0) begin
                int t, h, n, last, e, i;
                bit at_edge, lead;
                t    = m_t[d];
                h    = m_h[d];
                n    = m_n[d];
                last = (2 * n + 1) * h;
                e    = t / h;
                if (e > 2 * n) e = 2 * n;
                e_sclk[d] = cpol_of(d) ^ (e % 2);
                e_busy[d] = (t < last) ? 1 : 0;
                e_done[d] = (t == last) ? 1 : 0;
                i       = t / h;
                at_edge = (t > 0) && (t % h == 0) && (i <= 2 * n);
                lead    = (i % 2) == 1;
                if (cpha_of(d) == 1) begin
                    e_launch[d] = (at_edge && lead) ? 1 : 0;
                    e_sample[d] = (at_edge && !lead) ? 1 : 0;
                end else begin
                    e_sample[d] = (at_edge && lead) ? 1 : 0;
                    e_launch[d] = ((at_edge && !lead && i != 2 * n) || (t == 0 && n > 0)) ? 1 : 0;
                end
                if (e_done[d] != 0) m_act[d] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("sclk0",   int'(bus0.sclk),          e_sclk[0]);
        check_eq("launch0", int'(bus0.launch_strobe), e_launch[0]);
        check_eq("sample0", int'(bus0.sample_strobe), e_sample[0]);
        check_eq("busy0",   int'(bus0.busy),          e_busy[0]);
        check_eq("done0",   int'(bus0.done),          e_done[0]);
        check_eq("sclk1",   int'(bus1.sclk),          e_sclk[1]);
        check_eq("launch1", int'(bus1.launch_strobe), e_launch[1]);
        check_eq("sample1", int'(bus1.sample_strobe), e_sample[1]);
        check_eq("busy1",   int'(bus1.busy),          e_busy[1]);
        check_eq("done1",   int'(bus1.done),          e_done[1]);
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            cnt_busy[d]   = 0;
            cnt_edges[d]  = 0;
            cnt_launch[d] = 0;
            cnt_sample[d] = 0;
            cnt_done[d]   = 0;
        end
        prev_sclk[0] = int'(bus0.sclk);
        prev_sclk[1] = int'(bus1.sclk);
    endtask

    task automatic tally_one(input int d, input int sc, input int la, input int sa, input int bu, input int dn);
        cnt_busy[d]   += bu;
        cnt_launch[d] += la;
        cnt_sample[d] += sa;
        cnt_done[d]   += dn;
        if (sc != prev_sclk[d]) cnt_edges[d]++;
        prev_sclk[d] = sc;
    endtask

    // Entered and left at posedge+1 so inputs never change near the active edge
    task automatic cycle(input bit s, input bit a, input int hd, input int bc);
        drive(s, a, hd, bc);
        @(posedge system_clock);
        model_step(s, a, hd, bc);
        #1;
        compare_all();
        tally_one(0, int'(bus0.sclk), int'(bus0.launch_strobe), int'(bus0.sample_strobe),
                  int'(bus0.busy), int'(bus0.done));
        tally_one(1, int'(bus1.sclk), int'(bus1.launch_strobe), int'(bus1.sample_strobe),
                  int'(bus1.busy), int'(bus1.done));
    endtask

    task automatic mid_reset();
        drive(1'b0, 1'b0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;
            set_idle(d);
        end
        compare_all();
        @(posedge system_clock);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;
            m_t[d]   = 0;
            m_h[d]   = 1;
            m_n[d]   = 0;
            set_idle(d);
        end
        drive(1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge system_clock);
        #1;
        compare_all();
        reset = 1'b0;

        // ADS131A0x default frame; configuration wiggles while busy must not matter
        clear_stats();
        cycle(1'b1, 1'b0, 6, 24);
        repeat (300) cycle(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 63));
        check_eq("busy_cycles0", cnt_busy[0], 294);
        check_eq("sclk_edges0",  cnt_edges[0], 48);
        check_eq("launches0",    cnt_launch[0], 24);
        check_eq("samples0",     cnt_sample[0], 24);
        check_eq("dones0",       cnt_done[0], 1);
        check_eq("sclk_edges1",  cnt_edges[1], 48);
        check_eq("launches1",    cnt_launch[1], 24);
        check_eq("samples1",     cnt_sample[1], 24);

        // short frame, half_div of zero, empty frame
        cycle(1'b1, 1'b0, 2, 8);
        repeat (40) cycle(1'b0, 1'b0, 0, 0);
        clear_stats();
        cycle(1'b1, 1'b0, 0, 4);
        repeat (12) cycle(1'b0, 1'b0, 0, 0);
        check_eq("div0_edges0", cnt_edges[0], 8);
        clear_stats();
        cycle(1'b1, 1'b0, 5, 0);
        repeat (8) cycle(1'b0, 1'b0, 0, 0);
        check_eq("empty_edges0",  cnt_edges[0], 0);
        check_eq("empty_strobe1", cnt_launch[1] + cnt_sample[1], 0);
        check_eq("empty_done0",   cnt_done[0], 1);

        // abort at edge 10 with start held while busy, then start+abort together in idle
        clear_stats();
        cycle(1'b1, 1'b0, 3, 24);
        repeat (14) cycle(1'b1, 1'b0, 2, 2);
        repeat (15) cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 0, 0);
        cycle(1'b1, 1'b1, 3, 3);
        repeat (12) cycle(1'b0, 1'b0, 0, 0);
        check_eq("abort_dones0", cnt_done[0], 0);
        check_eq("abort_edges0", cnt_edges[0], 10);

        // reset mid-frame, then a normal frame
        cycle(1'b1, 1'b0, 4, 10);
        repeat (20) cycle(1'b0, 1'b0, 0, 0);
        mid_reset();
        cycle(1'b1, 1'b0, 2, 3);
        repeat (20) cycle(1'b0, 1'b0, 0, 0);

        // back-to-back frames with start held high
        repeat (40) cycle(1'b1, 1'b0, 1, 2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit s, a;
            int hd, bc;
            s  = ($urandom % 4) == 0;
            a  = ($urandom % 80) == 0;
            hd = $urandom_range(0, 5);
            bc = (($urandom % 8) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            if (($urandom % 1000) == 0) mid_reset();
            else cycle(s, a, hd, bc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
